// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if -- operand/result handshake bundle for booth_mul_seq.
//   mul_valid/mul_ready : operand request handshake (mul_signed, src_a, src_b)
//   flush               : abort the in-flight operation
//   res_valid/res_ready : result handshake (res_hi, res_lo)
//   busy                : multiplier not idle
// slave  = multiplier side, master = EX-stage / writeback side.
interface booth_mul_seq_if;
   logic        mul_valid;
   logic        mul_ready;
   logic        mul_signed;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        busy;

   modport slave (
      input  mul_valid, mul_signed, src_a, src_b, flush, res_ready,
      output mul_ready, res_valid, res_hi, res_lo, busy
   );

   modport master (
      output mul_valid, mul_signed, src_a, src_b, flush, res_ready,
      input  mul_ready, res_valid, res_hi, res_lo, busy
   );
endinterface

// File: rtl/booth_mul_seq.sv
// booth_mul_seq -- sequential 32x32 radix-4 Booth multiplier (MULT/MULTU).
// One Booth digit per clock is added into a 64-bit accumulator; 17 digits
// cover the 35-bit extended multiplier.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous reset, active low
//   bus    : booth_mul_seq_if.slave (operand handshake, flush, result handshake)
// Optional build macro BOOTH_MUL_EARLY_TERM_EN: finish as soon as all
// remaining Booth digits are zero. Results are identical in both builds.
module booth_mul_seq (
   input  logic           clk,
   input  logic           resetn,
   booth_mul_seq_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t      state;
   logic [32:0] ax;        // multiplicand, extended by one sign/zero bit
   logic [34:0] bx;        // {e,e,src_b,1'b0}
   logic [4:0]  cnt;       // current digit index 0..16
   logic [63:0] acc;
   logic [63:0] res;       // result shadow: only loaded on entry to DONE
   logic        mul_ready_q, res_valid_q, busy_q;

   logic [5:0]  sh;        // 2*cnt
   logic [2:0]  grp;
   logic [63:0] a64, mag, pp, acc_nxt;
   logic        d_zero, d_dbl, d_neg, last;

   assign sh  = {cnt, 1'b0};
   assign grp = 3'(bx >> sh);
   assign a64 = {{31{ax[32]}}, ax};

   always_comb begin
      d_zero = 1'b0;
      d_dbl  = 1'b0;
      d_neg  = 1'b0;
      case (grp)
         3'b000, 3'b111: d_zero = 1'b1;
         3'b001, 3'b010: ;
         3'b011:         d_dbl  = 1'b1;
         3'b100:         begin d_dbl = 1'b1; d_neg = 1'b1; end
         default:        d_neg  = 1'b1;   // 101, 110
      endcase
   end

   // Negative digits: invert the magnitude at its own weight and inject the
   // +1 at bit 2i, giving the exact two's complement partial product.
   always_comb begin
      mag = d_zero ? 64'd0 : (d_dbl ? {a64[62:0], 1'b0} : a64);
      pp  = d_neg ? (((~mag) << sh) + (64'd1 << sh)) : (mag << sh);
   end

   assign acc_nxt = acc + pp;

`ifdef BOOTH_MUL_EARLY_TERM_EN
   // Arithmetic shift replicates bx[34], so the window Bx[34:2i+2] is
   // uniform exactly when the shifted value is all-0 or all-1.
   logic [34:0] rem;
   assign rem  = 35'($signed(bx) >>> (sh + 6'd2));
   assign last = (cnt == 5'd16) || (&rem) || (~|rem);
`else
   assign last = (cnt == 5'd16);
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         ax          <= '0;
         bx          <= '0;
         cnt         <= '0;
         acc         <= '0;
         res         <= '0;
         mul_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (bus.flush) begin
         // flush wins over every handshake; the in-flight result is dropped
         state       <= S_IDLE;
         mul_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.mul_valid) begin
                  ax          <= {bus.mul_signed & bus.src_a[31], bus.src_a};
                  bx          <= {{2{bus.mul_signed & bus.src_b[31]}}, bus.src_b, 1'b0};
                  acc         <= '0;
                  cnt         <= '0;
                  state       <= S_CALC;
                  mul_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            S_CALC: begin
               acc <= acc_nxt;
               if (last) begin
                  res         <= acc_nxt;
                  res_valid_q <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            S_DONE: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  mul_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: begin
               state       <= S_IDLE;
               mul_ready_q <= 1'b1;
               res_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mul_ready = mul_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.busy      = busy_q;
   assign bus.res_hi    = res[63:32];
   assign bus.res_lo    = res[31:0];

endmodule
